apb_alu_master: RTL and testbench

//   APB master bridge, directly upstream of the ALU slave on PSEL2 and of a

---
 rtl/apb_pkg.sv | 25 ++
 rtl/apb_timeout_counter.sv | 30 +++
 rtl/apb_alu_master.sv | 128 ++++++++++++
 tb/tb_apb_alu_master.sv | 172 +++++++++++++++++
 4 files changed

// File: rtl/apb_pkg.sv
// Shared types and constants for the APB master bridge and the ALU slave register layout.
package apb_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2
  } state_e;

  localparam int DATA_W = 32;

  localparam logic [1:0] ALU_OP_ADD = 2'b00;
  localparam logic [1:0] ALU_OP_SUB = 2'b01;
  localparam logic [1:0] ALU_OP_MUL = 2'b10;
  localparam logic [1:0] ALU_OP_XOR = 2'b11;

  // Operand/opcode packing inside PWDATA for the ALU slave
  localparam int ALU_A_LSB  = 0;
  localparam int ALU_A_MSB  = 6;
  localparam int ALU_B_LSB  = 7;
  localparam int ALU_B_MSB  = 13;
  localparam int ALU_OP_LSB = 14;
  localparam int ALU_OP_MSB = 15;

endpackage

// File: rtl/apb_timeout_counter.sv
// ACCESS-phase wait-state counter; tc_o flags the last permitted wait cycle.
module apb_timeout_counter #(
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic clk_i,
  input  logic rst_n_i,
  input  logic clear_i,
  input  logic inc_i,
  output logic tc_o
);

  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clear_i)    cnt_d = '0;
    else if (inc_i) cnt_d = cnt_q + 1'b1;
  end

  always_ff @(posedge clk_i) begin
    if (!rst_n_i) cnt_q <= '0;
    else          cnt_q <= cnt_d;
  end

  // Asserted when this stalled cycle would bring the count to TIMEOUT_CYCLES
  assign tc_o = inc_i && (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));

endmodule

// File: rtl/apb_alu_master.sv
// Valid/ready to APB bridge with PSEL1/PSEL2 decode on one address bit.
// Optional ACCESS timeout abort is enabled by defining APB_MASTER_TIMEOUT_EN.
module apb_alu_master
  import apb_pkg::*;
#(
  parameter int ADDR_W         = 9,
  parameter int SEL_BIT        = 8,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic              PCLK,
  input  logic              PRESETn,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              rsp_valid,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_err,
  output logic [ADDR_W-1:0] PADDR,
  output logic              PSEL1,
  output logic              PSEL2,
  output logic              PENABLE,
  output logic              PWRITE,
  output logic [DATA_W-1:0] PWDATA,
  input  logic [DATA_W-1:0] PRDATA,
  input  logic              PREADY
);

  state_e            state_q;
  logic              req_ready_q, rsp_valid_q, psel1_q, psel2_q, penable_q, pwrite_q;
  logic [DATA_W-1:0] rsp_rdata_q, pwdata_q;
  logic [ADDR_W-1:0] paddr_q;

`ifdef APB_MASTER_TIMEOUT_EN
  logic rsp_err_q;
  logic timeout_tc;

  apb_timeout_counter #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_timeout (
    .clk_i   (PCLK),
    .rst_n_i (PRESETn),
    .clear_i (state_q == SETUP),
    .inc_i   ((state_q == ACCESS) && !PREADY),
    .tc_o    (timeout_tc)
  );

  assign rsp_err = rsp_err_q;
`else
  assign rsp_err = 1'b0;
`endif

  always_ff @(posedge PCLK) begin
    if (!PRESETn) begin
      state_q     <= IDLE;
      req_ready_q <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= '0;
      psel1_q     <= 1'b0;
      psel2_q     <= 1'b0;
      penable_q   <= 1'b0;
      pwrite_q    <= 1'b0;
      pwdata_q    <= '0;
      paddr_q     <= '0;
`ifdef APB_MASTER_TIMEOUT_EN
      rsp_err_q   <= 1'b0;
`endif
    end else begin
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= '0;
`ifdef APB_MASTER_TIMEOUT_EN
      rsp_err_q   <= 1'b0;
`endif
      case (state_q)
        IDLE: begin
          if (req_valid && req_ready_q) begin
            req_ready_q <= 1'b0;
            pwrite_q    <= req_write;
            paddr_q     <= req_addr;
            pwdata_q    <= req_wdata;
            psel1_q     <= !req_addr[SEL_BIT];
            psel2_q     <= req_addr[SEL_BIT];
            state_q     <= SETUP;
          end else begin
            req_ready_q <= 1'b1;
          end
        end
        SETUP: begin
          penable_q <= 1'b1;
          state_q   <= ACCESS;
        end
        ACCESS: begin
          if (PREADY) begin
            psel1_q     <= 1'b0;
            psel2_q     <= 1'b0;
            penable_q   <= 1'b0;
            rsp_valid_q <= 1'b1;
            rsp_rdata_q <= pwrite_q ? '0 : PRDATA;
            req_ready_q <= 1'b1;
            state_q     <= IDLE;
          end
`ifdef APB_MASTER_TIMEOUT_EN
          else if (timeout_tc) begin
            psel1_q     <= 1'b0;
            psel2_q     <= 1'b0;
            penable_q   <= 1'b0;
            rsp_valid_q <= 1'b1;
            rsp_err_q   <= 1'b1;
            req_ready_q <= 1'b1;
            state_q     <= IDLE;
          end
`endif
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign req_ready = req_ready_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_rdata = rsp_rdata_q;
  assign PADDR     = paddr_q;
  assign PSEL1     = psel1_q;
  assign PSEL2     = psel2_q;
  assign PENABLE   = penable_q;
  assign PWRITE    = pwrite_q;
  assign PWDATA    = pwdata_q;

endmodule

// File: tb/tb_apb_alu_master.sv
// Directed + randomized bench for apb_alu_master acting as the APB slave.
// Follows APB_MASTER_TIMEOUT_EN the same way the RTL does.
module tb_apb_alu_master;
  import apb_pkg::*;

  localparam int TMO = 16;

  logic        PCLK = 1'b0;
  logic        PRESETn = 1'b0;
  logic        req_valid = 1'b0, req_write = 1'b0;
  logic [8:0]  req_addr = '0;
  logic [31:0] req_wdata = '0, PRDATA = '0;
  logic        PREADY = 1'b0;
  logic        req_ready, rsp_valid, rsp_err, PSEL1, PSEL2, PENABLE, PWRITE;
  logic [31:0] rsp_rdata, PWDATA;
  logic [8:0]  PADDR;

  int errors = 0;
  int checks = 0;

  apb_alu_master #(.ADDR_W(9), .SEL_BIT(8), .TIMEOUT_CYCLES(TMO)) dut (
    .PCLK(PCLK), .PRESETn(PRESETn),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .PADDR(PADDR), .PSEL1(PSEL1), .PSEL2(PSEL2), .PENABLE(PENABLE),
    .PWRITE(PWRITE), .PWDATA(PWDATA), .PRDATA(PRDATA), .PREADY(PREADY)
  );

  always #5 PCLK = ~PCLK;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, "_psel1"}, 32'(PSEL1), 32'd0);
    check({tag, "_psel2"}, 32'(PSEL2), 32'd0);
    check({tag, "_penable"}, 32'(PENABLE), 32'd0);
    check({tag, "_rsp_valid"}, 32'(rsp_valid), 32'd0);
  endtask

  // One request. The bench plays the slave: PREADY rises on ACCESS cycle waits+1.
  // hold > 0: stall PREADY low for 'hold' ACCESS cycles and return mid-transfer.
  task automatic txn(input logic wr, input logic [8:0] addr, input logic [31:0] wd,
                     input int waits, input logic [31:0] rd, input int hold);
    int  lat, acc, exp_acc;
    bit  done, exp_err;
    exp_err = 1'b0;
    exp_acc = waits + 1;
`ifdef APB_MASTER_TIMEOUT_EN
    if (waits >= TMO) begin
      exp_err = 1'b1;
      exp_acc = TMO;
    end
`endif
    req_valid = 1'b1; req_write = wr; req_addr = addr; req_wdata = wd;
    for (int i = 0; i < 20 && !req_ready; i++) @(negedge PCLK);
    check("accept_ready", 32'(req_ready), 32'd1);
    @(negedge PCLK);
    // Scramble request inputs: the bridge must have latched the accepted values
    req_valid = 1'b0; req_addr = 9'($urandom); req_wdata = $urandom; req_write = ~wr;
    check("setup_psel1", 32'(PSEL1), 32'(!addr[8]));
    check("setup_psel2", 32'(PSEL2), 32'(addr[8]));
    check("setup_penable", 32'(PENABLE), 32'd0);
    check("setup_paddr", 32'(PADDR), 32'(addr));
    check("setup_pwrite", 32'(PWRITE), 32'(wr));
    check("setup_pwdata", PWDATA, wd);
    check("setup_ready", 32'(req_ready), 32'd0);
    PREADY = 1'b1;  // must be ignored in SETUP
    PRDATA = $urandom;
    lat = 1; acc = 0; done = 1'b0;
    for (int i = 0; i < waits + 60 && !done; i++) begin
      @(negedge PCLK);
      lat++;
      if (rsp_valid) begin
        done = 1'b1;
      end else begin
        acc++;
        if (acc <= 3 || acc % 16 == 0) begin
          check("access_penable", 32'(PENABLE), 32'd1);
          check("access_psel", {30'd0, PSEL2, PSEL1}, {30'd0, addr[8], !addr[8]});
          check("access_paddr", 32'(PADDR), 32'(addr));
          check("access_pwdata", PWDATA, wd);
        end
        if (hold > 0 && acc == hold) begin
          PREADY = 1'b0;
          return;
        end
        PREADY = (acc > waits);
        PRDATA = (acc > waits) ? rd : $urandom;
      end
    end
    check("rsp_seen", 32'(done), 32'd1);
    if (done) begin
      check("rsp_latency", 32'(lat), 32'(exp_acc + 2));
      check("access_cycles", 32'(acc), 32'(exp_acc));
      check("rsp_rdata", rsp_rdata, (wr || exp_err) ? 32'd0 : rd);
      check("rsp_err", 32'(rsp_err), 32'(exp_err));
      check("done_psel", {30'd0, PSEL2, PSEL1}, 32'd0);
      check("done_penable", 32'(PENABLE), 32'd0);
      check("done_ready", 32'(req_ready), 32'd1);
    end
    PREADY = 1'b0;
    @(negedge PCLK);
    check("rsp_one_cycle", 32'(rsp_valid), 32'd0);
  endtask

  initial begin
    logic [31:0] alu_wd;
    // 1. reset held 3 cycles
    PRESETn = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge PCLK);
      check_idle_outputs("reset");
      check("reset_ready", 32'(req_ready), 32'd0);
      check("reset_misc", {rsp_rdata | PWDATA, 8'(0)} == 40'd0 && PADDR == 9'd0 &&
            !PWRITE && !rsp_err ? 32'd1 : 32'd0, 32'd1);
    end
    PRESETn = 1'b1;
    @(negedge PCLK);
    check("ready_after_reset", 32'(req_ready), 32'd1);

    // 2. ALU write A=5 B=3 ADD to PSEL2, PREADY on 2nd ACCESS cycle
    alu_wd = '0;
    alu_wd[ALU_A_MSB:ALU_A_LSB]   = 7'd5;
    alu_wd[ALU_B_MSB:ALU_B_LSB]   = 7'd3;
    alu_wd[ALU_OP_MSB:ALU_OP_LSB] = ALU_OP_ADD;
    check("alu_wdata_pack", alu_wd, 32'h0000_0185);
    txn(1'b1, 9'h100, alu_wd, 1, 32'hDEAD_BEEF, 0);
    // 3. read result 8 back
    txn(1'b0, 9'h100, 32'h0, 0, 32'h0000_0008, 0);
    // 4. read PSEL1 peripheral, zero wait-states
    txn(1'b0, 9'h004, 32'h0, 0, 32'h1234_5678, 0);

    // randomized transactions against the model inside txn
    for (int n = 0; n < 24; n++)
      txn(1'($urandom), 9'($urandom), $urandom, int'($urandom_range(0, 4)), $urandom, 0);

    // 5. PREADY stuck low
`ifdef APB_MASTER_TIMEOUT_EN
    txn(1'b0, 9'h100, 32'h0, TMO, 32'hCAFE_F00D, 0);
    txn(1'b0, 9'h004, 32'h0, TMO - 1, 32'hCAFE_F00D, 0);
    txn(1'b1, 9'h100, 32'h55, 3, 32'h0, 3);
`else
    txn(1'b0, 9'h100, 32'h0, 100000, 32'hCAFE_F00D, 120);
    check("stuck_penable", 32'(PENABLE), 32'd1);
    check("stuck_psel2", 32'(PSEL2), 32'd1);
    check("stuck_no_rsp", 32'(rsp_valid), 32'd0);
`endif

    // 6. reset while in ACCESS
    PRESETn = 1'b0;
    @(negedge PCLK);
    check_idle_outputs("midreset");
    @(negedge PCLK);
    check_idle_outputs("midreset2");
    PRESETn = 1'b1;
    @(negedge PCLK);
    check("no_rsp_after_abort", 32'(rsp_valid), 32'd0);
    txn(1'b0, 9'h1A5, 32'h0, 2, 32'h0BAD_CAFE, 0);
    txn(1'b1, 9'h033, 32'hA5A5_5A5A, 0, 32'h0, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
